// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences host weight commands onto the UDX/XX/XY weight RAMs.
// The command word is {op[1:0], sel[1:0], addr[AW-1:0], data[WS-1:0]}.
// sel: 00 = UDX, 01 = XX, 10 = XY, 11 = illegal.
// op:  00 = WRITE, 01 = READ, 10 = CLEAR, 11 = illegal.
// Optional feature macro: WEIT_CLEAR_EN builds the CLEAR sweep.
// Without it, CLEAR commands are dropped and flagged in oErr.
module weight_load_ctrl #(
    parameter  int NI     = 1,
    parameter  int NO     = 1,
    parameter  int NH     = 64,
    parameter  int WS     = 8,
    localparam int D_UDX  = (NI + NO) * NH,
    localparam int D_XX   = NH * NH,
    localparam int D_XY   = NH * NO,
    localparam int AW_UDX = (D_UDX > 1) ? $clog2(D_UDX) : 1,
    localparam int AW_XX  = (D_XX > 1) ? $clog2(D_XX) : 1,
    localparam int AW_XY  = (D_XY > 1) ? $clog2(D_XY) : 1,
    localparam int AW_T   = (AW_UDX > AW_XX) ? AW_UDX : AW_XX,
    localparam int AW     = (AW_T > AW_XY) ? AW_T : AW_XY,
    localparam int CW     = 4 + AW + WS
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid_AS_WeitCmd,
    output logic              oReady_AS_WeitCmd,
    input  logic [CW-1:0]     iData_AS_WeitCmd,
    output logic              oValid_BM_WeitRd,
    input  logic              iReady_BM_WeitRd,
    output logic [WS-1:0]     oData_BM_WeitRd,
    input  logic              iIdle_Network,
    output logic              oHold_Network,
    output logic              oErr,
    output logic              oWE_Weit_UDX,
    output logic [AW_UDX-1:0] oAddr_Weit_UDX,
    output logic [WS-1:0]     oData_Weit_UDX,
    input  logic [WS-1:0]     iData_Weit_UDX,
    output logic              oWE_Weit_XX,
    output logic [AW_XX-1:0]  oAddr_Weit_XX,
    output logic [WS-1:0]     oData_Weit_XX,
    input  logic [WS-1:0]     iData_Weit_XX,
    output logic              oWE_Weit_XY,
    output logic [AW_XY-1:0]  oAddr_Weit_XY,
    output logic [WS-1:0]     oData_Weit_XY,
    input  logic [WS-1:0]     iData_Weit_XY
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] SEL_UDX  = 2'b00;
    localparam logic [1:0] SEL_XX   = 2'b01;
    localparam logic [1:0] SEL_XY   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RADDR,
        ST_RDATA,
        ST_RRESP
`ifdef WEIT_CLEAR_EN
        , ST_CLEAR
`endif
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [1:0]      r_sel;
    logic [1:0]      w_nextSel;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_nextAddr;
    logic [WS-1:0]   r_data;
    logic [WS-1:0]   w_nextData;
    logic            r_we;
    logic            w_nextWe;
    logic            r_valid;
    logic            w_nextValid;
    logic [WS-1:0]   r_rdData;
    logic [WS-1:0]   w_nextRdData;
    logic            r_err;
    logic            w_nextErr;

    logic            w_accept;
    logic [1:0]      w_cmdOp;
    logic [1:0]      w_cmdSel;
    logic [AW-1:0]   w_cmdAddr;
    logic [WS-1:0]   w_cmdData;
    logic            w_selBad;
    logic            w_addrBad;
    logic            w_cmdBad;

`ifdef WEIT_CLEAR_EN
    logic [AW:0]     r_clrCnt;
    logic [AW:0]     w_nextClrCnt;
    logic [AW:0]     w_clrCntInc;
    logic [AW:0]     w_curDepth;
`endif

    // Bank depth for a select code; the illegal code maps to depth 0 so any address is out of range.
    function automatic logic [AW:0] depthOf(input logic [1:0] sel);
        case (sel)
            SEL_UDX: return (AW + 1)'(D_UDX);
            SEL_XX:  return (AW + 1)'(D_XX);
            SEL_XY:  return (AW + 1)'(D_XY);
            default: return '0;
        endcase
    endfunction

    assign w_cmdOp   = iData_AS_WeitCmd[CW-1 -: 2];
    assign w_cmdSel  = iData_AS_WeitCmd[CW-3 -: 2];
    assign w_cmdAddr = iData_AS_WeitCmd[WS +: AW];
    assign w_cmdData = iData_AS_WeitCmd[WS-1:0];

    assign oReady_AS_WeitCmd = (r_state == ST_IDLE) & iIdle_Network;
    assign w_accept          = iValid_AS_WeitCmd & oReady_AS_WeitCmd;
    assign oHold_Network     = (r_state != ST_IDLE);

    assign w_selBad  = (w_cmdSel == 2'b11);
    assign w_addrBad = ({1'b0, w_cmdAddr} >= depthOf(w_cmdSel));

    // Classify the incoming command; dropped commands still handshake but only raise oErr.
    always_comb begin
        w_cmdBad = 1'b1;
        case (w_cmdOp)
            OP_WRITE: w_cmdBad = w_selBad | w_addrBad;
            OP_READ:  w_cmdBad = w_selBad | w_addrBad;
`ifdef WEIT_CLEAR_EN
            OP_CLEAR: w_cmdBad = w_selBad;
`else
            OP_CLEAR: w_cmdBad = 1'b1;
`endif
            default:  w_cmdBad = 1'b1;
        endcase
    end

`ifdef WEIT_CLEAR_EN
    assign w_clrCntInc = r_clrCnt + {{AW{1'b0}}, 1'b1};
    assign w_curDepth  = depthOf(r_sel);
`endif

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        w_nextState  = r_state;
        w_nextSel    = r_sel;
        w_nextAddr   = r_addr;
        w_nextData   = r_data;
        w_nextWe     = 1'b0;
        w_nextValid  = r_valid;
        w_nextRdData = r_rdData;
        w_nextErr    = r_err;
`ifdef WEIT_CLEAR_EN
        w_nextClrCnt = r_clrCnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmdBad) begin
                        w_nextErr = 1'b1;
                    end else if (w_cmdOp == OP_WRITE) begin
                        w_nextState = ST_WRITE;
                        w_nextSel   = w_cmdSel;
                        w_nextAddr  = w_cmdAddr;
                        w_nextData  = w_cmdData;
                        w_nextWe    = 1'b1;
                    end else if (w_cmdOp == OP_READ) begin
                        w_nextState = ST_RADDR;
                        w_nextSel   = w_cmdSel;
                        w_nextAddr  = w_cmdAddr;
                    end
`ifdef WEIT_CLEAR_EN
                    else begin
                        w_nextState  = ST_CLEAR;
                        w_nextSel    = w_cmdSel;
                        w_nextAddr   = '0;
                        w_nextData   = '0;
                        w_nextWe     = 1'b1;
                        w_nextClrCnt = '0;
                    end
`endif
                end
            end
            ST_WRITE: w_nextState = ST_IDLE;
            ST_RADDR: w_nextState = ST_RDATA;
            ST_RDATA: begin
                w_nextState = ST_RRESP;
                w_nextValid = 1'b1;
                case (r_sel)
                    SEL_UDX: w_nextRdData = iData_Weit_UDX;
                    SEL_XX:  w_nextRdData = iData_Weit_XX;
                    default: w_nextRdData = iData_Weit_XY;
                endcase
            end
            ST_RRESP: begin
                if (iReady_BM_WeitRd) begin
                    w_nextState = ST_IDLE;
                    w_nextValid = 1'b0;
                end
            end
`ifdef WEIT_CLEAR_EN
            ST_CLEAR: begin
                if (r_clrCnt == w_curDepth) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextClrCnt = w_clrCntInc;
                    if (w_clrCntInc < w_curDepth) begin
                        w_nextWe   = 1'b1;
                        w_nextAddr = w_clrCntInc[AW-1:0];
                    end
                end
            end
`endif
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access and discards a pending response.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_we     <= 1'b0;
            r_valid  <= 1'b0;
            r_rdData <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_sel    <= w_nextSel;
            r_addr   <= w_nextAddr;
            r_data   <= w_nextData;
            r_we     <= w_nextWe;
            r_valid  <= w_nextValid;
            r_rdData <= w_nextRdData;
            r_err    <= w_nextErr;
        end
    end

`ifdef WEIT_CLEAR_EN
    // Sweep counter for CLEAR; reset returns it to zero so an aborted sweep restarts cleanly.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_clrCnt <= '0;
        end else begin
            r_clrCnt <= w_nextClrCnt;
        end
    end
`endif

    assign oValid_BM_WeitRd = r_valid;
    assign oData_BM_WeitRd  = r_rdData;
    assign oErr             = r_err;

    assign oWE_Weit_UDX   = r_we & (r_sel == SEL_UDX);
    assign oWE_Weit_XX    = r_we & (r_sel == SEL_XX);
    assign oWE_Weit_XY    = r_we & (r_sel == SEL_XY);
    assign oAddr_Weit_UDX = r_addr[AW_UDX-1:0];
    assign oAddr_Weit_XX  = r_addr[AW_XX-1:0];
    assign oAddr_Weit_XY  = r_addr[AW_XY-1:0];
    assign oData_Weit_UDX = r_data;
    assign oData_Weit_XX  = r_data;
    assign oData_Weit_XY  = r_data;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed bench for weight_load_ctrl with NI=1, NO=1, NH=64, WS=8.
// Bank RAMs are modelled here; expected writes and read responses go through queues.
module tb_weight_load_ctrl;

    localparam int NI = 1;
    localparam int NO = 1;
    localparam int NH = 64;
    localparam int WS = 8;
    localparam int AW = 12;
    localparam int CW = 4 + AW + WS;

    typedef struct {
        int         bank;
        logic [11:0] addr;
        logic [7:0]  data;
    } wrItem_t;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iValid = 1'b0;
    logic          oReady;
    logic [CW-1:0] iData = '0;
    logic          oValid;
    logic          iReady = 1'b0;
    logic [WS-1:0] oData;
    logic          iIdle = 1'b0;
    logic          oHold;
    logic          oErr;
    logic          weUdx, weXx, weXy;
    logic [6:0]    addrUdx;
    logic [11:0]   addrXx;
    logic [5:0]    addrXy;
    logic [7:0]    dUdx, dXx, dXy;
    logic [7:0]    rdUdx = '0, rdXx = '0, rdXy = '0;

    logic [7:0]    udxMem [128];
    logic [7:0]    xxMem  [4096];
    logic [7:0]    xyMem  [64];

    wrItem_t       writeQ [$];
    logic [7:0]    readQ  [$];
    int            checks = 0;
    int            errors = 0;

    weight_load_ctrl #(.NI(NI), .NO(NO), .NH(NH), .WS(WS)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iValid_AS_WeitCmd(iValid), .oReady_AS_WeitCmd(oReady), .iData_AS_WeitCmd(iData),
        .oValid_BM_WeitRd(oValid), .iReady_BM_WeitRd(iReady), .oData_BM_WeitRd(oData),
        .iIdle_Network(iIdle), .oHold_Network(oHold), .oErr(oErr),
        .oWE_Weit_UDX(weUdx), .oAddr_Weit_UDX(addrUdx), .oData_Weit_UDX(dUdx), .iData_Weit_UDX(rdUdx),
        .oWE_Weit_XX(weXx), .oAddr_Weit_XX(addrXx), .oData_Weit_XX(dXx), .iData_Weit_XX(rdXx),
        .oWE_Weit_XY(weXy), .oAddr_Weit_XY(addrXy), .oData_Weit_XY(dXy), .iData_Weit_XY(rdXy)
    );

    always #5 iCLK = ~iCLK;

    // Synchronous single-port bank RAMs with one cycle of read latency.
    always @(posedge iCLK) begin
        if (weUdx) udxMem[addrUdx] <= dUdx;
        if (weXx)  xxMem[addrXx]   <= dXx;
        if (weXy)  xyMem[addrXy]   <= dXy;
        rdUdx <= udxMem[addrUdx];
        rdXx  <= xxMem[addrXx];
        rdXy  <= xyMem[addrXy];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse seen mid-cycle must match the oldest expected write.
    always @(negedge iCLK) begin
        int      nWe;
        int      obsBank;
        logic [11:0] obsAddr;
        logic [7:0]  obsData;
        wrItem_t exp;
        nWe = int'(weUdx) + int'(weXx) + int'(weXy);
        if (nWe != 0) begin
            obsBank = weUdx ? 0 : (weXx ? 1 : 2);
            obsAddr = weUdx ? {5'd0, addrUdx} : (weXx ? addrXx : {6'd0, addrXy});
            obsData = weUdx ? dUdx : (weXx ? dXx : dXy);
            checkOutput("write onehot", nWe, 1);
            if (writeQ.size() == 0) begin
                checkOutput("unexpected write bank", obsBank, 32'hFFFF_FFFF);
            end else begin
                exp = writeQ.pop_front();
                checkOutput("write bank", obsBank, exp.bank);
                checkOutput("write addr", obsAddr, exp.addr);
                checkOutput("write data", obsData, exp.data);
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] sel,
                                 input logic [11:0] addr, input logic [7:0] data);
        iValid = 1'b1;
        iData  = {op, sel, addr, data};
        tick();
        iValid = 1'b0;
    endtask

    task automatic doReset();
        iRST   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        writeQ.delete();
        readQ.delete();
        tick();
        tick();
        iRST = 1'b1;
        tick();
    endtask

    task automatic pushWrite(input int bank, input logic [11:0] addr, input logic [7:0] data);
        wrItem_t it;
        it.bank = bank;
        it.addr = addr;
        it.data = data;
        writeQ.push_back(it);
    endtask

    initial begin
        int          holdCount;
        logic [7:0]  expRd;

        // Reset state with the network busy so ready is low too.
        iIdle = 1'b0;
        iRST  = 1'b0;
        #12;
        checkOutput("reset ready", oReady, 0);
        checkOutput("reset hold", oHold, 0);
        checkOutput("reset valid", oValid, 0);
        checkOutput("reset err", oErr, 0);
        checkOutput("reset we", {weUdx, weXx, weXy}, 0);
        checkOutput("reset rdata", oData, 0);
        iRST = 1'b1;
        iIdle = 1'b1;
        tick();
        checkOutput("idle ready", oReady, 1);

        // WRITE XX addr 5 data 0x3C.
        pushWrite(1, 12'd5, 8'h3C);
        applyStimulus(2'b00, 2'b01, 12'd5, 8'h3C);
        checkOutput("wr xx we", weXx, 1);
        checkOutput("wr xx addr", addrXx, 5);
        checkOutput("wr xx data", dXx, 8'h3C);
        checkOutput("wr others we", {weUdx, weXy}, 0);
        checkOutput("wr hold", oHold, 1);
        tick();
        checkOutput("wr done hold", oHold, 0);
        checkOutput("wr done we", weXx, 0);

        // WRITE UDX 7 = 0xA5, then READ it back with a stalled consumer.
        pushWrite(0, 12'd7, 8'hA5);
        applyStimulus(2'b00, 2'b00, 12'd7, 8'hA5);
        tick();
        readQ.push_back(8'hA5);
        applyStimulus(2'b01, 2'b00, 12'd7, 8'h00);
        checkOutput("rd T+1 valid", oValid, 0);
        checkOutput("rd T+1 hold", oHold, 1);
        checkOutput("rd T+1 addr", addrUdx, 7);
        tick();
        checkOutput("rd T+2 valid", oValid, 0);
        tick();
        checkOutput("rd T+3 valid", oValid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rd stall valid", oValid, 1);
        end
        iReady = 1'b1;
        expRd = readQ.pop_front();
        checkOutput("rd data", oData, expRd);
        tick();
        iReady = 1'b0;
        checkOutput("rd after hs valid", oValid, 0);
        checkOutput("rd after hs hold", oHold, 0);

        // Network busy blocks acceptance; raising idle lets it through that cycle.
        iIdle  = 1'b0;
        iValid = 1'b1;
        iData  = {2'b00, 2'b10, 12'd3, 8'h11};
        #1;
        checkOutput("busy ready", oReady, 0);
        tick();
        tick();
        checkOutput("busy hold", oHold, 0);
        checkOutput("busy we", weXy, 0);
        iIdle = 1'b1;
        #1;
        checkOutput("unbusy ready", oReady, 1);
        pushWrite(2, 12'd3, 8'h11);
        tick();
        iValid = 1'b0;
        checkOutput("unbusy hold", oHold, 1);
        checkOutput("unbusy we xy", weXy, 1);
        checkOutput("unbusy addr xy", addrXy, 3);
        tick();

        // Out-of-range XY address is dropped and flags the sticky error.
        applyStimulus(2'b00, 2'b10, 12'd64, 8'h77);
        checkOutput("badaddr err", oErr, 1);
        checkOutput("badaddr hold", oHold, 0);
        checkOutput("badaddr we", {weUdx, weXx, weXy}, 0);
        pushWrite(1, 12'd1, 8'h02);
        applyStimulus(2'b00, 2'b01, 12'd1, 8'h02);
        tick();
        checkOutput("err sticky", oErr, 1);

        // sel=11 dropped.
        doReset();
        checkOutput("err cleared", oErr, 0);
        applyStimulus(2'b00, 2'b11, 12'd0, 8'h55);
        checkOutput("badsel err", oErr, 1);
        checkOutput("badsel hold", oHold, 0);

        // op=11 dropped.
        doReset();
        applyStimulus(2'b11, 2'b00, 12'd0, 8'h55);
        checkOutput("badop err", oErr, 1);
        checkOutput("badop hold", oHold, 0);

        // CLEAR of XY.
        doReset();
`ifdef WEIT_CLEAR_EN
        for (int a = 0; a < 64; a++) pushWrite(2, 12'(a), 8'h00);
        applyStimulus(2'b10, 2'b10, 12'd9, 8'hFF);
        holdCount = 0;
        for (int i = 0; i < 200 && oHold; i++) begin
            holdCount++;
            tick();
        end
        checkOutput("clear hold cycles", holdCount, 65);
        checkOutput("clear writes left", writeQ.size(), 0);
        checkOutput("clear err", oErr, 0);
        for (int a = 0; a < 64; a++) pushWrite(2, 12'(a), 8'h00);
        applyStimulus(2'b10, 2'b10, 12'd0, 8'h00);
        for (int i = 0; i < 9; i++) tick();
        iRST = 1'b0;
        #1;
        checkOutput("clear abort we", weXy, 0);
        checkOutput("clear abort hold", oHold, 0);
        doReset();
        for (int a = 0; a < 64; a++) pushWrite(2, 12'(a), 8'h00);
        applyStimulus(2'b10, 2'b10, 12'd0, 8'h00);
        checkOutput("clear restart addr", addrXy, 0);
        for (int i = 0; i < 200 && oHold; i++) tick();
        checkOutput("clear2 writes left", writeQ.size(), 0);
`else
        holdCount = 0;
        applyStimulus(2'b10, 2'b10, 12'd0, 8'h00);
        checkOutput("noclear err", oErr, 1);
        checkOutput("noclear hold", oHold, holdCount);
        tick();
        checkOutput("noclear we", weXy, 0);
`endif

        // Reset during RRESP discards the pending response.
        doReset();
        readQ.push_back(8'h11);
        applyStimulus(2'b01, 2'b10, 12'd3, 8'h00);
        for (int i = 0; i < 10 && !oValid; i++) tick();
        checkOutput("rresp reached", oValid, 1);
        expRd = readQ.pop_front();
        checkOutput("rresp data", oData, expRd);
        #2;
        iRST = 1'b0;
        #1;
        checkOutput("rst valid async", oValid, 0);
        checkOutput("rst hold async", oHold, 0);
        tick();
        iRST = 1'b1;
        iIdle = 1'b0;
        tick();
        checkOutput("post rst ready busy", oReady, 0);
        iIdle = 1'b1;
        #1;
        checkOutput("post rst ready idle", oReady, 1);

        // Read with consumer always ready: handshake on the first valid cycle.
        readQ.push_back(8'hA5);
        iReady = 1'b1;
        applyStimulus(2'b01, 2'b00, 12'd7, 8'h00);
        tick();
        tick();
        checkOutput("fast rd valid", oValid, 1);
        expRd = readQ.pop_front();
        checkOutput("fast rd data", oData, expRd);
        tick();
        checkOutput("fast rd done", oValid, 0);
        checkOutput("fast rd hold", oHold, 0);
        iReady = 1'b0;

        tick();
        checkOutput("writeQ drained", writeQ.size(), 0);
        checkOutput("readQ drained", readQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
